// File: rtl/emergency_request_conditioner.sv
// emergency_request_conditioner: sync, debounce, hold and arbitrate left/right emergency sensor lines.
// Define FAULT_LOCKOUT_EN to add the stuck-sensor LOCKOUT state and fault_left/fault_right.
module emergency_request_conditioner #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 3,
  parameter int HOLD_CYCLES       = 10,
  parameter int MAX_ACTIVE_CYCLES = 60,
  parameter int CNT_W             = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_left,
  input  logic raw_right,
  input  logic clear,
  output logic emergency_left,
  output logic emergency_right,
  output logic fault_left,
  output logic fault_right
);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_LIM = (HOLD_CYCLES > MAX_ACTIVE_CYCLES) ? HOLD_CYCLES : MAX_ACTIVE_CYCLES;
  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
`ifdef FAULT_LOCKOUT_EN
    HOLD,
    LOCKOUT
`else
    HOLD
`endif
  } state_t;
  logic [1:0] w_raw, w_req;
`ifdef FAULT_LOCKOUT_EN
  logic [1:0] w_fault;
`endif
  assign w_raw = {raw_right, raw_left};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic r_deb, w_sync, w_db_done;
    state_t r_state;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_inc;
    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_db_done  = r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1);
    assign w_hold_inc = (r_hold_cnt >= CNT_W'(CNT_LIM)) ? r_hold_cnt : r_hold_cnt + 1'b1;
    assign w_req[c]   = (r_state == ACTIVE) || (r_state == HOLD);
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_sync   <= '0;
        r_db_cnt <= '0;
        r_deb    <= 1'b0;
      end else begin
        r_sync   <= {r_sync[SYNC_STAGES-2:0], w_raw[c]};
        r_db_cnt <= (w_sync == r_deb || w_db_done) ? '0 : r_db_cnt + 1'b1;
        r_deb    <= r_deb ^ (w_sync != r_deb && w_db_done);
      end
`ifdef FAULT_LOCKOUT_EN
    logic [CNT_W-1:0] r_act_cnt, w_act_inc;
    assign w_act_inc  = (r_act_cnt >= CNT_W'(CNT_LIM)) ? r_act_cnt : r_act_cnt + 1'b1;
    assign w_fault[c] = r_state == LOCKOUT;
    always_ff @(posedge clk or posedge reset)
      if (reset || clear) begin
        r_state    <= IDLE;
        r_hold_cnt <= '0;
        r_act_cnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_hold_cnt <= '0;
            r_act_cnt  <= '0;
            r_state    <= r_deb ? ACTIVE : IDLE;
          end
          ACTIVE: begin
            r_act_cnt  <= w_act_inc;
            r_hold_cnt <= '0;
            r_state    <= (w_act_inc >= CNT_W'(MAX_ACTIVE_CYCLES)) ? LOCKOUT : (r_deb ? ACTIVE : HOLD);
          end
          HOLD: begin
            r_hold_cnt <= w_hold_inc;
            r_state    <= r_deb ? ACTIVE : ((w_hold_inc >= CNT_W'(HOLD_CYCLES)) ? IDLE : HOLD);
          end
          default: r_state <= r_deb ? LOCKOUT : IDLE;
        endcase
      end
`else
    always_ff @(posedge clk or posedge reset)
      if (reset || clear) begin
        r_state    <= IDLE;
        r_hold_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_hold_cnt <= '0;
            r_state    <= r_deb ? ACTIVE : IDLE;
          end
          ACTIVE: begin
            r_hold_cnt <= '0;
            r_state    <= r_deb ? ACTIVE : HOLD;
          end
          HOLD: begin
            r_hold_cnt <= w_hold_inc;
            r_state    <= r_deb ? ACTIVE : ((w_hold_inc >= CNT_W'(HOLD_CYCLES)) ? IDLE : HOLD);
          end
          default: r_state <= IDLE;
        endcase
      end
`endif
  end
  // Right wins; a masked left request stays alive in its FSM and surfaces once right releases.
  always_ff @(posedge clk or posedge reset)
    if (reset || clear) begin
      emergency_left  <= 1'b0;
      emergency_right <= 1'b0;
    end else begin
      emergency_right <= w_req[1];
      emergency_left  <= w_req[0] & ~w_req[1];
    end
`ifdef FAULT_LOCKOUT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset || clear) begin
      fault_left  <= 1'b0;
      fault_right <= 1'b0;
    end else begin
      fault_left  <= w_fault[0];
      fault_right <= w_fault[1];
    end
`else
  assign fault_left  = 1'b0;
  assign fault_right = 1'b0;
`endif
endmodule

// File: tb/tb_emergency_request_conditioner.sv
// tb_emergency_request_conditioner: vector table, corner sequences and randomized run against a reference model.
module tb_emergency_request_conditioner;
  localparam int SY = 2, DB = 3, HO = 10, MX = 60;
`ifdef FAULT_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk, reset, raw_left, raw_right, clear;
  logic emergency_left, emergency_right, fault_left, fault_right;
  int tests = 0, fails = 0;
  emergency_request_conditioner #(
    .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HO),
    .MAX_ACTIVE_CYCLES(MX), .CNT_W(7)
  ) dut (
    .clk(clk), .reset(reset), .raw_left(raw_left), .raw_right(raw_right), .clear(clear),
    .emergency_left(emergency_left), .emergency_right(emergency_right),
    .fault_left(fault_left), .fault_right(fault_right)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Reference: raw history delay line, run-length debounce, mode numbers 0 idle/1 active/2 hold/3 lockout.
  logic [1:0] rawq[$];
  bit lvl[2];
  int run[2], mode[2], hc[2], ac[2];
  logic m_el, m_er, m_fl, m_fr;
  function automatic void model_reset();
    rawq = {};
    for (int i = 0; i < SY; i++) rawq.push_back(2'b00);
    for (int c = 0; c < 2; c++) begin
      lvl[c] = 1'b0; run[c] = 0; mode[c] = 0; hc[c] = 0; ac[c] = 0;
    end
    {m_el, m_er, m_fl, m_fr} = 4'b0000;
  endfunction
  function automatic void model_edge(logic rl, logic rr, logic cl);
    logic [1:0] s, rq, fl;
    s = rawq.pop_front();
    rawq.push_back({rr, rl});
    for (int c = 0; c < 2; c++) begin
      rq[c] = (mode[c] == 1) || (mode[c] == 2);
      fl[c] = mode[c] == 3;
    end
    m_er = !cl && rq[1];
    m_el = !cl && rq[0] && !rq[1];
    m_fl = !cl && fl[0];
    m_fr = !cl && fl[1];
    for (int c = 0; c < 2; c++) begin
      if (cl) begin
        mode[c] = 0; hc[c] = 0; ac[c] = 0;
      end else begin
        case (mode[c])
          0: begin ac[c] = 0; hc[c] = 0; if (lvl[c]) mode[c] = 1; end
          1: begin
            ac[c]++;
            if (LOCK && ac[c] >= MX) mode[c] = 3;
            else if (!lvl[c]) begin mode[c] = 2; hc[c] = 0; end
          end
          2: begin
            hc[c]++;
            if (lvl[c]) mode[c] = 1;
            else if (hc[c] >= HO) mode[c] = 0;
          end
          default: if (!lvl[c]) mode[c] = 0;
        endcase
      end
      if (s[c] == lvl[c]) run[c] = 0;
      else begin
        run[c]++;
        if (run[c] == DB) begin lvl[c] = !lvl[c]; run[c] = 0; end
      end
    end
  endfunction
  function automatic void chk(string nm, logic [3:0] act, logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got {el,er,fl,fr}=%b expected %b", nm, $time, act, exp);
    end
  endfunction
  function automatic logic [3:0] outs();
    return {emergency_left, emergency_right, fault_left, fault_right};
  endfunction
  task automatic step(input logic rl, input logic rr, input logic cl);
    raw_left = rl; raw_right = rr; clear = cl;
    @(posedge clk);
    #1;
    model_edge(rl, rr, cl);
    chk("model", outs(), {m_el, m_er, m_fl, m_fr});
    chk("exclusive", {3'b000, emergency_left & emergency_right}, 4'b0000);
  endtask
  task automatic do_reset();
    reset = 1'b1; raw_left = 1'b0; raw_right = 1'b0; clear = 1'b0;
    @(posedge clk);
    #1;
    chk("reset", outs(), 4'b0000);
    reset = 1'b0;
    model_reset();
  endtask
  typedef struct { bit rl, rr, cl; int n; bit el, er; } vec_t;
  vec_t tbl[$];
  initial begin
    int rise, fall, hi, lcnt, rcnt;
    logic lv, rv;
    tbl.push_back('{1'b0, 1'b1, 1'b0, 6,  1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 6,  1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 9,  1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 15, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 2,  1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8,  1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1,  1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 17, 1'b0, 1'b0});
    model_reset();
    do_reset();
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rl, tbl[i].rr, tbl[i].cl);
      chk($sformatf("vec%0d", i), outs(), {tbl[i].el, tbl[i].er, 2'b00});
    end
    // 20-cycle press: rises 6 edges in, stays 30 cycles, falls 16 edges after release.
    rise = -1; fall = -1; hi = 0;
    for (int i = 0; i < 50; i++) begin
      step(i < 20, 1'b0, 1'b0);
      if (emergency_left) begin hi++; if (rise < 0) rise = i; end
      else if (rise >= 0 && fall < 0) fall = i;
    end
    chk("press_rise", 4'(rise), 4'(6));
    chk("press_fall", {emergency_left, 3'b000}, 4'b0000);
    tests++; if (fall != 36 || hi != 30) begin fails++; $display("FAIL press_len: fall=%0d high=%0d expected fall=36 high=30", fall, hi); end
    // Asynchronous reset in the middle of HOLD.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);
    chk("mid_hold", outs(), 4'b1000);
    #2 reset = 1'b1;
    #1 chk("async_reset", outs(), 4'b0000);
    do_reset();
    hi = 0;
    for (int i = 0; i < 20; i++) begin step(1'b0, 1'b0, 1'b0); hi += emergency_left; end
    tests++; if (hi != 0) begin fails++; $display("FAIL post_reset_hold: high cycles=%0d expected 0", hi); end
`ifdef FAULT_LOCKOUT_EN
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 65) chk("pre_lockout", outs(), 4'b0100);
      if (i == 66) chk("lockout", outs(), 4'b0001);
    end
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (i == 5) chk("fault_hold", outs(), 4'b0001);
      if (i == 6) chk("fault_exit", outs(), 4'b0000);
    end
    for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'b0);
    chk("relock", outs(), 4'b0001);
    step(1'b0, 1'b1, 1'b1);
    chk("clear_fault", outs(), 4'b0000);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("reactive", outs(), 4'b0100);
`endif
    // Randomized bursts: short glitches and long presses, occasional clear.
    do_reset();
    lcnt = 0; rcnt = 0; lv = 1'b0; rv = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (lcnt == 0) begin lv = 1'($urandom); lcnt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 80); end
      if (rcnt == 0) begin rv = 1'($urandom); rcnt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 80); end
      lcnt--; rcnt--;
      step(lv, rv, $urandom_range(0, 199) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
